// File: rtl/mc_core.sv
// mc_core: multi-cycle register/register core. It fetches from a registered
// instruction ROM and reaches data memory through a req/ack port that tolerates wait states.
module mc_core #(
    parameter int W  = 8,
    parameter int D  = 3,
    parameter int PW = 10,
    parameter int CW = 16
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             start,
    output logic [PW-1:0]    imem_addr,
    input  logic [3+2*D-1:0] imem_data,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [W-1:0]     dmem_addr,
    output logic [W-1:0]     dmem_wdata,
    input  logic             dmem_ack,
    input  logic [W-1:0]     dmem_rdata,
    output logic             halt,
    output logic             busy,
    output logic [CW-1:0]    cycle_ct,
    output logic [CW-1:0]    instr_ct,
    output logic [2:0]       dbg_state
);
    localparam int IW = 3 + 2 * D;
    localparam int NR = 1 << D;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_BZ  = 3'b101;

    state_t         state_q, state_d;
    logic [PW-1:0]  pc_q, pc_d;
    logic           c_q, c_d;
    logic [W-1:0]   regs_q [NR];
    logic [W-1:0]   regs_d [NR];
    logic [CW-1:0]  cycle_ct_q, cycle_ct_d;
    logic [CW-1:0]  instr_ct_q, instr_ct_d;
    logic           halt_q, halt_d;
    logic           busy_q, busy_d;
    logic           req_q, req_d;
    logic           we_q, we_d;
    logic [W-1:0]   addr_q, addr_d;
    logic [W-1:0]   wdata_q, wdata_d;
    logic [D-1:0]   ld_ra_q, ld_ra_d;

    logic [2:0]     op;
    logic [D-1:0]   ra, rb;
    logic [W-1:0]   ra_val, rb_val;
    logic [W:0]     add_sum;
    logic [PW-1:0]  pc_inc, br_off;
    logic [CW-1:0]  instr_inc;

    assign op      = imem_data[IW-1 -: 3];
    assign ra      = imem_data[2*D-1 -: D];
    assign rb      = imem_data[D-1:0];
    assign ra_val  = regs_q[ra];
    assign rb_val  = regs_q[rb];
    assign add_sum = {1'b0, ra_val} + {1'b0, rb_val} + {{W{1'b0}}, c_q};
    assign pc_inc  = pc_q + PW'(1);
    assign br_off  = {{(PW-D){rb[D-1]}}, rb};
    // Counters stick at all-ones rather than wrapping.
    assign instr_inc = (&instr_ct_q) ? instr_ct_q : instr_ct_q + CW'(1);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        c_d        = c_q;
        regs_d     = regs_q;
        cycle_ct_d = cycle_ct_q;
        instr_ct_d = instr_ct_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ld_ra_d    = ld_ra_q;

        if (busy_q && !(&cycle_ct_q)) begin
            cycle_ct_d = cycle_ct_q + CW'(1);
        end

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d    = S_FETCH;
                    pc_d       = '0;
                    c_d        = 1'b0;
                    cycle_ct_d = '0;
                    instr_ct_d = '0;
                end
            end
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                state_d    = S_FETCH;
                pc_d       = pc_inc;
                instr_ct_d = instr_inc;
                case (op)
                    OP_ADD: {c_d, regs_d[ra]} = add_sum;
                    OP_SUB: begin
                        regs_d[ra] = ra_val - rb_val;
                        c_d        = ra_val < rb_val;
                    end
                    OP_AND: regs_d[ra] = ra_val & rb_val;
                    OP_XOR: regs_d[ra] = ra_val ^ rb_val;
                    OP_SHL: {c_d, regs_d[ra]} = {ra_val, c_q};
                    OP_BZ: begin
                        if (rb == '0) begin
                            state_d    = S_HALT;
                            pc_d       = pc_q;
                            instr_ct_d = instr_ct_q;
                        end else if (ra_val == '0) begin
                            pc_d = pc_q + br_off;
                        end
                    end
                    default: begin
                        // LD/ST: operands are latched so the port stays stable through wait states.
                        state_d    = S_MEM;
                        pc_d       = pc_q;
                        instr_ct_d = instr_ct_q;
                        req_d      = 1'b1;
                        we_d       = op[0];
                        addr_d     = rb_val;
                        wdata_d    = ra_val;
                        ld_ra_d    = ra;
                    end
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    state_d    = S_FETCH;
                    req_d      = 1'b0;
                    pc_d       = pc_inc;
                    instr_ct_d = instr_inc;
                    if (!we_q) begin
                        regs_d[ld_ra_q] = dmem_rdata;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_FETCH) || (state_d == S_EXEC) || (state_d == S_MEM);
        halt_d = (state_d == S_HALT);
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            c_q        <= 1'b0;
            for (int i = 0; i < NR; i++) begin
                regs_q[i] <= '0;
            end
            cycle_ct_q <= '0;
            instr_ct_q <= '0;
            halt_q     <= 1'b0;
            busy_q     <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ld_ra_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            c_q        <= c_d;
            regs_q     <= regs_d;
            cycle_ct_q <= cycle_ct_d;
            instr_ct_q <= instr_ct_d;
            halt_q     <= halt_d;
            busy_q     <= busy_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ld_ra_q    <= ld_ra_d;
        end
    end

    assign imem_addr  = pc_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign halt       = halt_q;
    assign busy       = busy_q;
    assign cycle_ct   = cycle_ct_q;
    assign instr_ct   = instr_ct_q;
    assign dbg_state  = state_q;
endmodule
